linecard_dest_router: RTL and testbench

LINECARD_DEST_ROUTER -- requirements
Module: linecard_dest_router

---
 rtl/linecard_dest_router.sv | 258 +++++++++++++++++++++++++
 tb/tb_linecard_dest_router.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linecard_dest_router.sv
// linecard_dest_router
//
// Routes an AXI-Stream frame to a set of crossbar outputs. Line cards come
// first, then the single-port uplinks. The destination is decoded once, on
// the first beat of each frame. The decoded result is then held for the
// rest of the frame. A frame whose unicast destination is out of range is
// handled in one of two ways, chosen by DROP_INVALID:
//   - it is dropped, or
//   - it is forwarded with an empty crossbar mask.
//
// m_tdest layout: [MSB] broadcast, then PORT_BITS of dest port, then the
// NUM_OUT-bit crossbar mask in the low bits.
//
// The output stage is a two-entry skid buffer:
//   - one cycle of latency,
//   - full throughput,
//   - s_tready comes straight from a register.
//
// Optional feature: define LINECARD_DEST_ROUTER_STATS_EN to add two sets of
// saturating counters:
//   - frame_count: frames forwarded, one counter per output,
//   - drop_count: frames dropped.

module linecard_dest_router #(
    parameter int DATA_WIDTH     = 64,
    parameter int USER_WIDTH     = 12,
    parameter int NUM_CARDS      = 2,
    parameter int PORTS_PER_CARD = 24,
    parameter int NUM_UPLINKS    = 2,
    parameter int PORT_BITS      = 6,
    parameter int DROP_INVALID   = 1,
    localparam int NUM_OUT       = NUM_CARDS + NUM_UPLINKS,
    localparam int TDEST_W       = 1 + PORT_BITS + NUM_OUT
) (
    input  logic                    aclk,
    input  logic                    rst,

    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tlast,
    input  logic [USER_WIDTH-1:0]   s_tuser,
    input  logic [PORT_BITS:0]      s_tdest,

    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tlast,
    output logic [USER_WIDTH-1:0]   m_tuser,
    output logic [TDEST_W-1:0]      m_tdest
`ifdef LINECARD_DEST_ROUTER_STATS_EN
    ,
    output logic [NUM_OUT*32-1:0]   frame_count,
    output logic [31:0]             drop_count
`endif
);

    localparam int  LC_PORTS = NUM_CARDS * PORTS_PER_CARD;
    localparam int  BEAT_W   = DATA_WIDTH + 1 + USER_WIDTH + TDEST_W;
    localparam logic DROP_EN = (DROP_INVALID != 0);

    // The port space must cover every line-card port and every uplink.
    if (LC_PORTS + NUM_UPLINKS > 2 ** PORT_BITS) begin : g_param_check
        $error("linecard_dest_router: NUM_CARDS*PORTS_PER_CARD+NUM_UPLINKS exceeds 2**PORT_BITS");
    end

    typedef enum logic [1:0] {
        ST_SOF  = 2'd0,   // waiting for the first beat of a frame
        ST_FWD  = 2'd1,   // mid-frame, beats forwarded with the held decode
        ST_DROP = 2'd2    // mid-frame, beats swallowed
    } state_t;

    state_t                 state;

    // Decode that was captured on the first beat of the current frame.
    logic                   hold_bcast;
    logic [PORT_BITS-1:0]   hold_port;
    logic [NUM_OUT-1:0]     hold_mask;

    // Live decode of s_tdest. It is only used on the first beat of a frame.
    logic                   in_bcast;
    logic [PORT_BITS-1:0]   in_port;
    logic [31:0]            port_ext;
    logic [NUM_OUT-1:0]     dec_mask;
    logic                   dec_valid;

    // Per-beat routing decision.
    logic [TDEST_W-1:0]     cur_tdest;
    logic                   fwd_beat;
    logic                   s_accept;
    logic                   push;
    logic [BEAT_W-1:0]      in_beat;

    // Skid buffer: an output register plus one overflow entry.
    logic                   out_valid;
    logic [BEAT_W-1:0]      out_beat;
    logic                   skid_valid;
    logic [BEAT_W-1:0]      skid_beat;
    logic                   skid_fill;

    assign in_bcast = s_tdest[PORT_BITS];
    assign in_port  = s_tdest[PORT_BITS-1:0];
    assign port_ext = 32'(in_port);

    // Turn the destination field into a crossbar mask.
    // An empty mask means the unicast port is out of range.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block leaves it unassigned (no latch).
        dec_mask  = '0;
        dec_valid = 1'b0;
        if (in_bcast) begin
            dec_mask  = '1;
            dec_valid = 1'b1;
        end else begin
            for (int c = 0; c < NUM_CARDS; c++) begin
                if (port_ext >= 32'(c * PORTS_PER_CARD) &&
                    port_ext <  32'((c + 1) * PORTS_PER_CARD)) begin
                    dec_mask[c] = 1'b1;
                    dec_valid   = 1'b1;
                end
            end
            for (int k = 0; k < NUM_UPLINKS; k++) begin
                if (port_ext == 32'(LC_PORTS + k)) begin
                    dec_mask[NUM_CARDS + k] = 1'b1;
                    dec_valid               = 1'b1;
                end
            end
        end
    end

    // Choose the tdest for this beat, and decide whether it is forwarded.
    // - First beat: use the live decode.
    // - Later beats: use the held copy.
    always_comb begin
        cur_tdest = {hold_bcast, hold_port, hold_mask};
        fwd_beat  = (state == ST_FWD);
        if (state == ST_SOF) begin
            cur_tdest = {in_bcast, in_port, dec_mask};
            fwd_beat  = dec_valid || !DROP_EN;
        end
    end

    assign s_accept = s_tvalid && s_tready;
    assign push     = s_accept && fwd_beat;
    assign in_beat  = {s_tdata, s_tlast, s_tuser, cur_tdest};

    // Frame FSM, plus capture of the first-beat decode.
    always_ff @(posedge aclk) begin
        if (rst) begin
            // NOTE: datapath registers are normally left unreset. These are
            // cleared on purpose, so the held decode starts from a known zero.
            state      <= ST_SOF;
            hold_bcast <= 1'b0;
            hold_port  <= '0;
            hold_mask  <= '0;
        end else if (s_accept) begin
            case (state)
                ST_SOF: begin
                    hold_bcast <= in_bcast;
                    hold_port  <= in_port;
                    hold_mask  <= dec_mask;
                    if (!s_tlast) begin
                        state <= fwd_beat ? ST_FWD : ST_DROP;
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (s_tlast) begin
                        state <= ST_SOF;
                    end
                end
                default: state <= ST_SOF;
            endcase
        end
    end

    // The skid entry fills on the next edge in two cases:
    // - it already holds a beat and the sink is stalled, or
    // - a new beat arrives while the output register is stalled.
    assign skid_fill = skid_valid ? !m_tready
                                  : (push && out_valid && !m_tready);

    // Two-entry skid buffer.
    // s_tready is registered, so m_tready has no combinational path to it.
    always_ff @(posedge aclk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            // Every register then updates from the same pre-edge values.
            out_valid  <= 1'b0;
            out_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
            s_tready   <= 1'b0;
        end else begin
            if (skid_valid) begin
                if (m_tready) begin
                    out_beat   <= skid_beat;
                    skid_valid <= 1'b0;
                end
            end else if (push) begin
                if (!out_valid || m_tready) begin
                    out_beat  <= in_beat;
                    out_valid <= 1'b1;
                end else begin
                    skid_beat  <= in_beat;
                    skid_valid <= 1'b1;
                end
            end else if (m_tready) begin
                out_valid <= 1'b0;
            end
            s_tready <= !skid_fill;
        end
    end

    assign m_tvalid = out_valid;
    assign m_tdata  = out_beat[BEAT_W-1 -: DATA_WIDTH];
    assign m_tlast  = out_beat[TDEST_W + USER_WIDTH];
    assign m_tuser  = out_beat[TDEST_W +: USER_WIDTH];
    assign m_tdest  = out_beat[TDEST_W-1:0];

`ifdef LINECARD_DEST_ROUTER_STATS_EN
    logic        m_accept;
    logic        drop_event;
    logic [31:0] frame_cnt [NUM_OUT];
    logic [31:0] drop_cnt;

    assign m_accept   = out_valid && m_tready;
    assign drop_event = s_accept && s_tlast &&
                        ((state == ST_DROP) || (state == ST_SOF && !fwd_beat));

    // Saturating counters:
    // - frame_cnt[i]: frames that finished on output i,
    // - drop_cnt: frames that were dropped.
    always_ff @(posedge aclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                frame_cnt[i] <= '0;
            end
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (m_accept && m_tlast && m_tdest[i] && frame_cnt[i] != '1) begin
                    frame_cnt[i] <= frame_cnt[i] + 32'd1;
                end
            end
            if (drop_event && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_frame_count
        assign frame_count[i*32 +: 32] = frame_cnt[i];
    end
    assign drop_count = drop_cnt;
`endif

endmodule

// File: tb/tb_linecard_dest_router.sv
// tb_linecard_dest_router
//
// Drives directed and random frames into linecard_dest_router. Every output
// beat is compared against a frame-level reference model.
// Two instances are used:
//   - u_dut_a: DROP_INVALID=1, the main device under test,
//   - u_dut_b: DROP_INVALID=0, used only for the forward-with-empty-mask case.

module tb_linecard_dest_router;

    localparam int DW  = 64;
    localparam int UW  = 12;
    localparam int NC  = 2;
    localparam int PPC = 24;
    localparam int NU  = 2;
    localparam int PB  = 6;
    localparam int NO  = NC + NU;
    localparam int TW  = 1 + PB + NO;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [UW-1:0] u;
        logic [TW-1:0] t;
    } beat_t;

    logic          aclk = 1'b0;
    logic          rst  = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          sel_b = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic [UW-1:0] s_tuser = '0;
    logic [PB:0]   s_tdest = '0;
    logic          m_tready;
    int            rdy_mode = 1;   // 0: stall, 1: always ready, 2: random

    logic          s_tvalid_a, s_tvalid_b, s_tready_a, s_tready_b, s_tready;
    logic          m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b;
    logic [DW-1:0] m_tdata_a, m_tdata_b;
    logic [UW-1:0] m_tuser_a, m_tuser_b;
    logic [TW-1:0] m_tdest_a, m_tdest_b;
`ifdef LINECARD_DEST_ROUTER_STATS_EN
    logic [NO*32-1:0] frame_count_a, frame_count_b;
    logic [31:0]      drop_count_a, drop_count_b;
`endif

    assign s_tvalid_a = s_tvalid && !sel_b;
    assign s_tvalid_b = s_tvalid && sel_b;
    assign s_tready   = sel_b ? s_tready_b : s_tready_a;

    always #5 aclk = ~aclk;

    linecard_dest_router #(.DROP_INVALID(1)) u_dut_a (
        .aclk(aclk), .rst(rst),
        .s_tvalid(s_tvalid_a), .s_tready(s_tready_a), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tdest(s_tdest),
        .m_tvalid(m_tvalid_a), .m_tready(m_tready), .m_tdata(m_tdata_a),
        .m_tlast(m_tlast_a), .m_tuser(m_tuser_a), .m_tdest(m_tdest_a)
`ifdef LINECARD_DEST_ROUTER_STATS_EN
        , .frame_count(frame_count_a), .drop_count(drop_count_a)
`endif
    );

    linecard_dest_router #(.DROP_INVALID(0)) u_dut_b (
        .aclk(aclk), .rst(rst),
        .s_tvalid(s_tvalid_b), .s_tready(s_tready_b), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tdest(s_tdest),
        .m_tvalid(m_tvalid_b), .m_tready(m_tready), .m_tdata(m_tdata_b),
        .m_tlast(m_tlast_b), .m_tuser(m_tuser_b), .m_tdest(m_tdest_b)
`ifdef LINECARD_DEST_ROUTER_STATS_EN
        , .frame_count(frame_count_b), .drop_count(drop_count_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Routing from the rules, written with plain arithmetic:
    // - broadcast sets every output,
    // - a card port sets bit p/PPC,
    // - an uplink port sets bit NC+k.
    function automatic logic [TW-1:0] ref_route(input logic [PB:0] d, output bit ok);
        logic [PB:0]   dv;
        logic [NO-1:0] mask;
        int            p;
        dv   = d;
        p    = int'(dv[PB-1:0]);
        mask = '0;
        ok   = 1'b1;
        if (dv[PB])                  mask = '1;
        else if (p < NC*PPC)         mask[p / PPC] = 1'b1;
        else if (p < NC*PPC + NU)    mask[NC + p - NC*PPC] = 1'b1;
        else                         ok = 1'b0;
        return {dv[PB], dv[PB-1:0], mask};
    endfunction

    // Reference model state.
    beat_t         exp_q[$];
    int            acc_q[$];
    bit            mdl_sof = 1'b1;
    bit            mdl_drop = 1'b0;
    logic [TW-1:0] mdl_td = '0;
    int unsigned   mdl_frames[NO];
    int unsigned   mdl_drops = 0;
    int            cyc = 0;
    bit            lat_check = 1'b0;
    beat_t         last_out = '0;
    int            out_beats = 0;
    bit            prev_stall = 1'b0;
    beat_t         prev_beat = '0;
    int            b_beats = 0;
    logic [TW-1:0] b_last_td = '0;

    always @(posedge aclk) cyc++;

    // Sink readiness pattern.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor and scoreboard. Everything here is sampled on the falling edge.
    always @(negedge aclk) begin
        beat_t cur, e;
        int    a;
        bit    ok;
        cur = {m_tdata_a, m_tlast_a, m_tuser_a, m_tdest_a};
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            mdl_sof    = 1'b1;
            mdl_drop   = 1'b0;
            prev_stall = 1'b0;
            mdl_drops  = 0;
            for (int i = 0; i < NO; i++) mdl_frames[i] = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_tvalid_a, 1'b1);
                check("stall_hold", cur, prev_beat);
            end
            if (m_tvalid_a && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_tvalid_a, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("beat", cur, e);
                    if (lat_check) check("latency", cyc, a + 1);
                    out_beats++;
                    last_out = cur;
                    if (e.l) begin
                        for (int i = 0; i < NO; i++) if (e.t[i]) mdl_frames[i]++;
                    end
                end
            end
            prev_stall = m_tvalid_a && !m_tready;
            prev_beat  = cur;
            if (!sel_b && s_tvalid && s_tready_a) begin
                if (mdl_sof) begin
                    mdl_td   = ref_route(s_tdest, ok);
                    mdl_drop = !ok;
                end
                if (!mdl_drop) begin
                    exp_q.push_back({s_tdata, s_tlast, s_tuser, mdl_td});
                    acc_q.push_back(cyc);
                end else if (s_tlast) begin
                    mdl_drops++;
                end
                mdl_sof = s_tlast;
            end
        end
        if (m_tvalid_b && m_tready) begin
            b_beats++;
            b_last_td = m_tdest_b;
        end
    end

    // Drive one beat and wait (bounded) until it is accepted.
    // The task returns just after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic last,
                             input logic [UW-1:0] u, input logic [PB:0] dest);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = u;
        s_tdest  = dest;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            if (s_tready && !rst) begin
                @(posedge aclk);
                #1;
                return;
            end
        end
        check("accept_timeout", s_tready, 1'b1);
    endtask

    task automatic send_frame(input logic [PB:0] dest, input logic [PB:0] later_dest,
                              input int len, input bit idle_after);
        logic [UW-1:0] u;
        u = UW'($urandom);
        for (int b = 0; b < len; b++) begin
            send_beat({$urandom, $urandom}, (b == len - 1), u, (b == 0) ? dest : later_dest);
        end
        if (idle_after) s_tvalid = 1'b0;
    endtask

    // Wait, with a bound, until every expected beat has come out.
    task automatic drain();
        for (int n = 0; n < 500; n++) begin
            if (exp_q.size() == 0 && !m_tvalid_a) return;
            @(posedge aclk);
            #1;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [PB:0] d, ld;

        // Reset behaviour: outputs cleared, s_tready low, then high one cycle later.
        rst = 1'b1;
        @(posedge aclk); #1;
        check("rst_s_tready", s_tready_a, 1'b0);
        check("rst_m_tvalid", m_tvalid_a, 1'b0);
        check("rst_m_tdata", m_tdata_a, '0);
        check("rst_m_tuser", m_tuser_a, '0);
        check("rst_m_tdest", m_tdest_a, '0);
        @(posedge aclk); #1;
        rst = 1'b0;
        @(posedge aclk); #1;
        check("post_rst_s_tready", s_tready_a, 1'b1);

        // Unicast to port 5: three beats, one-cycle latency.
        lat_check = 1'b1;
        base = out_beats;
        send_frame(7'd5, 7'd5, 3, 1'b1);
        drain();
        check("uc5_beats", out_beats - base, 3);
        check("uc5_mask", last_out.t[NO-1:0], 4'b0001);
        check("uc5_port", last_out.t[NO +: PB], 6'd5);

        // Later beats carry a different tdest, which must be ignored.
        send_frame(7'd30, 7'd48, 3, 1'b1);
        drain();
        check("hold_mask", last_out.t[NO-1:0], 4'b0010);
        check("hold_port", last_out.t[NO +: PB], 6'd30);

        // Broadcast, then the last uplink.
        send_frame({1'b1, 6'd0}, 7'd0, 2, 1'b1);
        drain();
        check("bc_mask", last_out.t[NO-1:0], 4'b1111);
        check("bc_flag", last_out.t[TW-1], 1'b1);
        send_frame(7'd49, 7'd49, 1, 1'b1);
        drain();
        check("uplink1_mask", last_out.t[NO-1:0], 4'b1000);

        // Invalid destination with DROP_INVALID=1: every beat accepted, nothing forwarded.
        base = out_beats;
        for (int b = 0; b < 4; b++) begin
            check("drop_tready", s_tready_a, 1'b1);
            send_beat({$urandom, $urandom}, (b == 3), 12'h0, 7'd55);
        end
        s_tvalid = 1'b0;
        repeat (4) begin @(posedge aclk); #1; end
        check("drop_no_output", out_beats - base, 0);
`ifdef LINECARD_DEST_ROUTER_STATS_EN
        check("drop_count_one", drop_count_a, 32'd1);
`endif

        // Invalid destination with DROP_INVALID=0: forwarded with an empty mask.
        sel_b = 1'b1;
        send_frame(7'd55, 7'd55, 2, 1'b1);
        repeat (4) begin @(posedge aclk); #1; end
        sel_b = 1'b0;
        check("fwd_inv_beats", b_beats, 2);
        check("fwd_inv_mask", b_last_td[NO-1:0], 4'b0000);
        check("fwd_inv_port", b_last_td[NO +: PB], 6'd55);

        // Random back-to-back frames under random backpressure.
        lat_check = 1'b0;
        rdy_mode  = 2;
        for (int f = 0; f < 60; f++) begin
            int r, len;
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 4);
            if (r == 0)      d = {1'b1, 6'($urandom)};
            else if (r == 1) d = {1'b0, 6'($urandom_range(50, 63))};
            else             d = {1'b0, 6'($urandom_range(0, 49))};
            ld = 7'($urandom);
            send_frame(d, ld, len, ($urandom_range(0, 3) == 0));
        end
        s_tvalid = 1'b0;
        rdy_mode = 1;
        drain();
`ifdef LINECARD_DEST_ROUTER_STATS_EN
        for (int i = 0; i < NO; i++) check("frame_count", frame_count_a[i*32 +: 32], mdl_frames[i]);
        check("drop_count", drop_count_a, mdl_drops);
`endif

        // Reset in the middle of a frame, then a fresh frame to uplink 0.
        rdy_mode = 0;
        @(posedge aclk); #1;
        send_beat({$urandom, $urandom}, 1'b0, 12'h0, 7'd10);
        check("pre_rst_buffered", m_tvalid_a, 1'b1);
        s_tdest = 7'd10;
        rst = 1'b1;
        @(posedge aclk); #1;
        check("mid_rst_m_tvalid", m_tvalid_a, 1'b0);
        rst = 1'b0;
        s_tvalid = 1'b0;
        @(posedge aclk); #1;
        check("after_rst_m_tvalid", m_tvalid_a, 1'b0);
        rdy_mode = 1;
        @(posedge aclk); #1;
        lat_check = 1'b1;
        send_frame(7'd48, 7'd10, 2, 1'b1);
        drain();
        check("post_rst_mask", last_out.t[NO-1:0], 4'b0100);
        check("post_rst_port", last_out.t[NO +: PB], 6'd48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
